// File: rtl/softmax_exp_row_ctrl.sv
// Row sequencer for the softmax exp stage: streams input tiles through exp_vec,
// registers each exp tile onto the output stream and accumulates the row sum.
module softmax_exp_row_ctrl #(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 16,
  parameter int TILE_SIZE = 4,
  parameter int ROW_TILES = 8,
  parameter int SUM_WIDTH = WIDTH + $clog2(TILE_SIZE * ROW_TILES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [WIDTH*TILE_SIZE-1:0]   s_data,
  output logic [WIDTH*TILE_SIZE-1:0]   exp_x_flat,
  input  logic [WIDTH*TILE_SIZE-1:0]   exp_y_flat,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [WIDTH*TILE_SIZE-1:0]   m_data,
  output logic                         m_last,
  output logic                         sum_valid,
  output logic [SUM_WIDTH-1:0]         sum_data,
  output logic                         done
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | accepting the row's input tiles
  // DRAIN | all tiles accepted, waiting for the m_last handshake
  // SUM   | one cycle: sum_valid/done asserted, sum_data updated
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, SUM} state_t;

  localparam int CNT_W = $clog2(ROW_TILES + 1);
  localparam logic [CNT_W-1:0] ROWS     = CNT_W'(ROW_TILES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROW_TILES - 1);

  if (ROW_TILES < 1 || FRAC >= WIDTH) begin : g_param_check
    $error("softmax_exp_row_ctrl: ROW_TILES must be >= 1 and FRAC < WIDTH");
  end

  state_t               state;
  logic [CNT_W-1:0]     in_cnt;
  logic [SUM_WIDTH-1:0] acc;
  logic [SUM_WIDTH-1:0] tile_sum;
  logic                 s_fire;
  logic                 m_fire;

  assign exp_x_flat = s_data;
  assign busy       = (state != IDLE);
  // One-entry output register: a stalled output blocks the input in the same cycle.
  assign s_ready    = (state == RUN) && (in_cnt < ROWS) && (!m_valid || m_ready);
  assign s_fire     = s_valid && s_ready;
  assign m_fire     = m_valid && m_ready;

  always_comb begin
    tile_sum = '0;
    for (int i = 0; i < TILE_SIZE; i++) begin
      tile_sum = tile_sum + SUM_WIDTH'($signed(exp_y_flat[i*WIDTH +: WIDTH]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_cnt    <= '0;
      acc       <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      sum_valid <= 1'b0;
      sum_data  <= '0;
      done      <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      done      <= 1'b0;

      if (s_fire) begin
        m_data  <= exp_y_flat;
        m_valid <= 1'b1;
        m_last  <= (in_cnt == LAST_IDX);
        in_cnt  <= in_cnt + 1'b1;
        acc     <= acc + tile_sum;
      end else if (m_fire) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            in_cnt   <= '0;
            acc      <= '0;
            sum_data <= '0;
          end
        end
        RUN: begin
          if (s_fire && in_cnt == LAST_IDX) state <= DRAIN;
        end
        DRAIN: begin
          if (m_fire && m_last) begin
            state     <= SUM;
            sum_data  <= acc;
            sum_valid <= 1'b1;
            done      <= 1'b1;
          end
        end
        SUM: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_exp_row_ctrl.sv
// Self-checking bench for softmax_exp_row_ctrl with a behavioural stand-in for exp_vec.
module tb_softmax_exp_row_ctrl;

  localparam int W  = 32;
  localparam int TS = 4;
  localparam int RT = 8;
  localparam int SW = W + $clog2(TS * RT);
  localparam int DW = W * TS;

  logic          clk = 1'b0;
  logic          rst, start, busy, s_valid, s_ready, m_valid, m_ready, m_last;
  logic          sum_valid, done;
  logic [DW-1:0] s_data, exp_x_flat, exp_y_flat, m_data;
  logic [SW-1:0] sum_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  softmax_exp_row_ctrl #(.WIDTH(W), .FRAC(16), .TILE_SIZE(TS), .ROW_TILES(RT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .exp_x_flat(exp_x_flat), .exp_y_flat(exp_y_flat),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .sum_valid(sum_valid), .sum_data(sum_data), .done(done)
  );

  // Known exp points for the directed vectors; any other input maps to an
  // arbitrary (possibly negative) value so sign extension gets exercised.
  function automatic logic [W-1:0] fexp_lane(input logic [W-1:0] x);
    case (x)
      32'h0000_0000: return 32'd65536;
      32'h0001_0000: return 32'd178145;
      32'hFFFF_8000: return 32'd39750;
      32'h0002_0000: return 32'd484249;
      default:       return {x[15:0], x[31:16]} ^ 32'h0001_0000;
    endcase
  endfunction

  function automatic logic [DW-1:0] fexp_tile(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    y = '0;
    for (int i = 0; i < TS; i++) y[i*W +: W] = fexp_lane(x[i*W +: W]);
    return y;
  endfunction

  function automatic longint lane_sum(input logic [DW-1:0] y);
    longint s;
    s = 0;
    for (int i = 0; i < TS; i++) s += longint'($signed(y[i*W +: W]));
    return s;
  endfunction

  assign exp_y_flat = fexp_tile(exp_x_flat);

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
  } vec_t;

  vec_t          tbl [RT];
  logic [DW-1:0] rowt [RT];

  // Full-throughput row with exact cycle-by-cycle expectations from tbl.
  task automatic run_table(input longint exp_sum);
    logic [SW-1:0] es;
    es = exp_sum[SW-1:0];
    @(negedge clk); start = 1'b1; m_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < RT; k++) begin
      s_valid = 1'b1; s_data = tbl[k].x;
      #1;
      chk($sformatf("s_ready tile%0d", k), DW'(s_ready), DW'(1));
      if (k > 0) begin
        chk($sformatf("m_valid tile%0d", k-1), DW'(m_valid), DW'(1));
        chk($sformatf("m_data tile%0d", k-1), m_data, tbl[k-1].y);
        chk($sformatf("m_last tile%0d", k-1), DW'(m_last), DW'(0));
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    #1;
    chk("m_valid last", DW'(m_valid), DW'(1));
    chk("m_data last", m_data, tbl[RT-1].y);
    chk("m_last last", DW'(m_last), DW'(1));
    chk("s_ready in drain", DW'(s_ready), DW'(0));
    @(negedge clk);
    chk("sum_valid pulse", DW'(sum_valid), DW'(1));
    chk("done pulse", DW'(done), DW'(1));
    chk("sum_data", DW'(sum_data), DW'(es));
    chk("m_valid after last", DW'(m_valid), DW'(0));
    @(negedge clk);
    chk("sum_valid low", DW'(sum_valid), DW'(0));
    chk("done low", DW'(done), DW'(0));
    chk("busy low after row", DW'(busy), DW'(0));
    chk("sum_data held", DW'(sum_data), DW'(es));
  endtask

  // Scoreboarded row over rowt with optional stall window, random handshakes
  // and a start signal held high while busy.
  task automatic stream_row(input int stall_at, input int stall_len, input bit rnd,
                            input bit poke_start);
    logic [DW-1:0] q[$];
    longint        sb;
    int            sent, got, lasts, dones, errs, cyc;
    bit            sum_seen, exp_sr;
    sb = 0; sent = 0; got = 0; lasts = 0; dones = 0; errs = 0; cyc = 0; sum_seen = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = poke_start;
    while (!sum_seen && cyc < 400) begin
      s_valid = (sent < RT) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      s_data  = (sent < RT) ? rowt[sent] : '0;
      m_ready = rnd ? ($urandom_range(0, 3) != 0)
                    : !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      exp_sr = (sent < RT) && (q.size() == 0 || m_ready);
      if (s_ready !== exp_sr) errs++;
      if (m_valid !== (q.size() != 0)) errs++;
      if (q.size() != 0 && m_data !== q[0]) errs++;
      if (m_valid && m_last !== (got == RT - 1)) errs++;
      if (busy !== 1'b1) errs++;
      if (sum_valid !== done) errs++;
      if (sum_valid) begin
        sum_seen = 1;
        dones++;
        if (got != RT || q.size() != 0) errs++;
        if (sum_data !== sb[SW-1:0]) errs++;
      end
      if (m_valid && m_ready) begin
        if (m_last) lasts++;
        void'(q.pop_front());
        got++;
      end
      if (s_valid && s_ready) begin
        q.push_back(fexp_tile(s_data));
        sb += lane_sum(fexp_tile(s_data));
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    chk("row finished in budget", DW'(sum_seen), DW'(1));
    chk("row protocol errors", DW'(errs), DW'(0));
    chk("row tiles out", DW'(got), DW'(RT));
    chk("row m_last count", DW'(lasts), DW'(1));
    chk("row done count", DW'(dones), DW'(1));
    #1;
    chk("row idle after sum", DW'(busy), DW'(0));
    chk("row sum held", DW'(sum_data), DW'(sb[SW-1:0]));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    #23;
    chk("reset busy", DW'(busy), DW'(0));
    chk("reset s_ready", DW'(s_ready), DW'(0));
    chk("reset m_valid", DW'(m_valid), DW'(0));
    chk("reset m_data", m_data, '0);
    chk("reset m_last", DW'(m_last), DW'(0));
    chk("reset sum_data", DW'(sum_data), DW'(0));
    chk("reset sum_valid", DW'(sum_valid), DW'(0));
    chk("reset done", DW'(done), DW'(0));
    @(negedge clk); rst = 1'b0;

    // s_valid in IDLE is not accepted
    s_valid = 1'b1; m_ready = 1'b1; s_data = {32'h0001_0000, 32'hFFFF_8000, 32'h0, 32'h0002_0000};
    #1;
    chk("exp_x passthrough", exp_x_flat, s_data);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("idle s_ready", DW'(s_ready), DW'(0));
      chk("idle busy/m_valid", DW'({busy, m_valid}), DW'(0));
    end
    s_valid = 1'b0;

    // Mixed row: tile 0 = {1.0,-0.5,0.0,2.0}, rest zero
    tbl[0].x = {32'h0001_0000, 32'hFFFF_8000, 32'h0000_0000, 32'h0002_0000};
    tbl[0].y = {32'd178145, 32'd39750, 32'd65536, 32'd484249};
    for (int k = 1; k < RT; k++) begin
      tbl[k].x = '0;
      tbl[k].y = {4{32'h0001_0000}};
    end
    run_table(64'd2602688);

    for (int k = 0; k < RT; k++) begin
      tbl[k].x = '0;
      tbl[k].y = {4{32'h0001_0000}};
    end
    run_table(64'h20_0000);

    // Stall of 5 clks mid-row with start held high throughout
    for (int k = 0; k < RT; k++) rowt[k] = {32'(k+1), 32'(k*3), 32'hFFFF_0000 - 32'(k), 32'(k) << 20};
    stream_row(3, 5, 1'b0, 1'b1);

    // Reset after 3 accepted tiles, then a clean zero row
    @(negedge clk); start = 1'b1; m_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = '0;
      @(negedge clk);
    end
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrow rst m_valid", DW'(m_valid), DW'(0));
    chk("midrow rst busy", DW'(busy), DW'(0));
    chk("midrow rst m_data", m_data, '0);
    chk("midrow rst sum/done", DW'({sum_valid, done}), DW'(0));
    @(negedge clk); rst = 1'b0;
    run_table(64'h20_0000);

    // Randomised rows
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < RT; k++) rowt[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
      stream_row(0, 0, 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
